// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: memory-side SECDED decoder. Walks N_WORDS little-endian
// 16-bit codewords starting at SRC_BASE, corrects/flags each one, and writes
// {d[7:0]} and {F, 3'b000, d[10:8]} back starting at DST_BASE.
module hamming_dec_engine #(
  parameter  int W          = 8,
  parameter  int byte_count = 256,
  parameter  int N_WORDS    = 15,
  parameter  int SRC_BASE   = 64,
  parameter  int DST_BASE   = 94,
  localparam int AW         = $clog2(byte_count)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  data_out,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] waddr,
  output logic [W-1:0]  data_in,
  output logic          write_en,
  output logic          busy,
  output logic          done,
  output logic [3:0]    err1_cnt,
  output logic [3:0]    err2_cnt
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_lo;
  logic [7:0]    r_res_lo, r_res_hi;
  logic [3:0]    r_err1, r_err2;

  logic [15:0]   w_cw, w_fix;
  logic [3:0]    w_syn;
  logic          w_pe;
  logic [1:0]    w_flag;
  logic [10:0]   w_data;
  logic [AW-1:0] w_off, w_src_lo, w_dst_lo;
  logic          w_last;

  // Word offset and wrapped source/destination addresses (modulo byte_count)
  assign w_off    = r_idx + r_idx;
  assign w_src_lo = AW'(SRC_BASE) + w_off;
  assign w_dst_lo = AW'(DST_BASE) + w_off;
  assign w_last   = (r_idx == AW'(N_WORDS - 1));

  assign err1_cnt = r_err1;
  assign err2_cnt = r_err2;

  // SECDED decode of the captured low byte and the live high byte
  always_comb begin
    w_cw  = {data_out, r_lo};
    w_syn = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (w_cw[k]) w_syn = w_syn ^ 4'(k);
    end
    w_pe   = ^w_cw;
    w_fix  = w_cw;
    w_flag = 2'b00;
    if (w_syn != '0 && w_pe) begin
      w_fix[w_syn] = ~w_cw[w_syn];
      w_flag       = 2'b01;
    end else if (w_syn == '0 && w_pe) begin
      w_flag = 2'b01;
    end else if (w_syn != '0 && !w_pe) begin
      w_flag = 2'b10;
    end
    w_data = {w_fix[15:9], w_fix[7:5], w_fix[3]};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state and state-decoded memory/status outputs
  always_comb begin
    w_next   = r_state;
    raddr    = '0;
    waddr    = '0;
    data_in  = '0;
    write_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = RD_LO;
      RD_LO: begin
        raddr  = w_src_lo;
        busy   = 1'b1;
        w_next = RD_HI;
      end
      RD_HI: begin
        raddr  = w_src_lo + AW'(1);
        busy   = 1'b1;
        w_next = WR_LO;
      end
      WR_LO: begin
        waddr    = w_dst_lo;
        data_in  = r_res_lo;
        write_en = 1'b1;
        busy     = 1'b1;
        w_next   = WR_HI;
      end
      WR_HI: begin
        waddr    = w_dst_lo + AW'(1);
        data_in  = r_res_hi;
        write_en = 1'b1;
        busy     = 1'b1;
        w_next   = w_last ? DONE : RD_LO;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: byte capture, result registers, word index, error counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx    <= '0;
      r_lo     <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_err1   <= '0;
      r_err2   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_idx  <= '0;
          r_err1 <= '0;
          r_err2 <= '0;
        end
        RD_LO: r_lo <= data_out;
        RD_HI: begin
          r_res_lo <= w_data[7:0];
          r_res_hi <= {w_flag, 3'b000, w_data[10:8]};
        end
        WR_HI: begin
          if (r_res_hi[7:6] == 2'b01) r_err1 <= r_err1 + 4'd1;
          if (r_res_hi[7:6] == 2'b10) r_err2 <= r_err2 + 4'd1;
          if (!w_last) r_idx <= r_idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
